// File: rtl/ada_fetch_pc.sv
// ada_fetch_pc: instruction-fetch PC stage for the ADA processor.
// Holds the PC, requests instruction memory, buffers one word in a skid slot when
// decode stalls, and redirects on branch/exception (exception wins).
// Optional feature: define ADA_FETCH_ALIGN_CHECK_EN to add o_if_misaligned and
// report misaligned redirect targets instead of fetching them.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | first cycle after reset release, no request
// FETCH   | request outstanding at pc_q
// HOLD    | output reg stalled, one word parked in skid, no request
// KILL    | redirected while a request was pending; wait ack, drop data
// PARK    | (align check only) misaligned target reported, no request
module ada_fetch_pc #(
   parameter logic [31:0] RESET_ADDR = 32'hBFC0_0000,
   parameter logic [31:0] PC_STEP    = 32'd4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_branch_taken,
   input  logic [31:0] i_branch_target,
   input  logic        i_exc_req,
   input  logic [31:0] i_exc_vector,
   input  logic        i_if_stall,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_ack,
   input  logic [31:0] i_imem_rdata,
   output logic [31:0] o_add_a,
   output logic [31:0] o_add_b,
   input  logic [31:0] i_add_c,
   output logic        o_if_valid,
   output logic [31:0] o_if_instr,
   output logic [31:0] o_if_pc,
   output logic [31:0] o_if_pc_next
`ifdef ADA_FETCH_ALIGN_CHECK_EN
   ,
   output logic        o_if_misaligned
`endif
);

`ifdef ADA_FETCH_ALIGN_CHECK_EN
   typedef enum logic [2:0] {ST_IDLE, ST_FETCH, ST_HOLD, ST_KILL, ST_PARK} state_t;
`else
   typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_HOLD, ST_KILL} state_t;
`endif

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_kill_addr;
   logic        r_valid;
   logic [31:0] r_instr;
   logic [31:0] r_pc_out;
   logic [31:0] r_pc_next_out;
   logic [31:0] r_skid_instr;
   logic [31:0] r_skid_pc;
   logic [31:0] r_skid_pc_next;

   logic        w_redirect;
   logic [31:0] w_target_raw;
   logic [31:0] w_target;
   logic        w_tgt_misal;
   logic        w_req;
   state_t      w_redir_dest;
   state_t      w_resume;

   assign w_redirect   = i_exc_req | i_branch_taken;
   assign w_target_raw = i_exc_req ? i_exc_vector : i_branch_target;
   assign w_req        = (r_state == ST_FETCH) || (r_state == ST_KILL);

`ifdef ADA_FETCH_ALIGN_CHECK_EN
   logic r_misal;
   assign w_target        = w_target_raw;
   assign w_tgt_misal     = |w_target_raw[1:0];
   assign w_redir_dest    = w_tgt_misal ? ST_PARK : ST_FETCH;
   assign w_resume        = r_misal ? ST_PARK : ST_FETCH;
   assign o_if_misaligned = r_misal;
`else
   // Without the checker the low target bits are simply dropped.
   logic w_unused_lsb;
   assign w_unused_lsb = ^w_target_raw[1:0];
   assign w_target     = {w_target_raw[31:2], 2'b00};
   assign w_tgt_misal  = 1'b0;
   assign w_redir_dest = ST_FETCH;
   assign w_resume     = ST_FETCH;
`endif

   // In KILL the bus still carries the abandoned address until it is acked.
   assign o_imem_req   = w_req;
   assign o_imem_addr  = (r_state == ST_KILL) ? r_kill_addr : r_pc;
   assign o_add_a      = r_pc;
   assign o_add_b      = PC_STEP;
   assign o_if_valid   = r_valid;
   assign o_if_instr   = r_instr;
   assign o_if_pc      = r_pc_out;
   assign o_if_pc_next = r_pc_next_out;

   // Fetch FSM: PC, request state, output register and skid slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= ST_IDLE;
         r_pc           <= RESET_ADDR;
         r_kill_addr    <= RESET_ADDR;
         r_valid        <= 1'b0;
         r_instr        <= 32'd0;
         r_pc_out       <= 32'd0;
         r_pc_next_out  <= 32'd0;
         r_skid_instr   <= 32'd0;
         r_skid_pc      <= 32'd0;
         r_skid_pc_next <= 32'd0;
`ifdef ADA_FETCH_ALIGN_CHECK_EN
         r_misal        <= 1'b0;
`endif
      end else if (w_redirect) begin
         r_pc    <= w_target;
         r_valid <= 1'b0;
`ifdef ADA_FETCH_ALIGN_CHECK_EN
         r_misal <= w_tgt_misal;
         if (w_tgt_misal) begin
            r_valid       <= 1'b1;
            r_instr       <= 32'd0;
            r_pc_out      <= w_target;
            r_pc_next_out <= w_target + PC_STEP;
         end
`endif
         // A request the memory has not yet acked must still complete.
         if (w_req && !i_imem_ack) begin
            r_state <= ST_KILL;
            if (r_state == ST_FETCH) r_kill_addr <= r_pc;
         end else begin
            r_state <= w_redir_dest;
         end
      end else begin
         case (r_state)
            ST_IDLE: r_state <= ST_FETCH;
            ST_FETCH: begin
               if (i_imem_ack) begin
                  r_pc <= i_add_c;
                  if (!r_valid || !i_if_stall) begin
                     r_valid       <= 1'b1;
                     r_instr       <= i_imem_rdata;
                     r_pc_out      <= r_pc;
                     r_pc_next_out <= i_add_c;
                  end else begin
                     r_skid_instr   <= i_imem_rdata;
                     r_skid_pc      <= r_pc;
                     r_skid_pc_next <= i_add_c;
                     r_state        <= ST_HOLD;
                  end
               end else if (!i_if_stall) begin
                  r_valid <= 1'b0;
               end
            end
            ST_HOLD: begin
               if (!i_if_stall) begin
                  r_instr       <= r_skid_instr;
                  r_pc_out      <= r_skid_pc;
                  r_pc_next_out <= r_skid_pc_next;
                  r_state       <= ST_FETCH;
               end
            end
            ST_KILL: begin
               if (i_imem_ack) r_state <= w_resume;
            end
            default: r_state <= r_state;
         endcase
      end
   end

endmodule
